// File: rtl/uart_ctrl.sv
// uart_ctrl: baud timing, TX/RX FSMs and FWFT FIFOs for a two-wire UART.
// Optional UART_LOOPBACK_EN: lpbk=1 feeds the internal txd into the RX path.
module uart_ctrl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       baud_div,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic              err_clr,
  input  logic              lpbk,
  output logic              tx_busy,
  output logic [2:0]        err,
  input  logic              rxd,
  output logic              txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PONE = (AW+1)'(1);
  localparam logic [2:0] LAST_D = 3'(DATA_W - 1);
  localparam logic [2:0] LAST_S = 3'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  logic [15:0] div_eff;
  assign div_eff = (baud_div < 16'd3) ? 16'd3 : baud_div;

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp, tx_rp;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PONE;
      if (tx_pop)  tx_rp <= tx_rp + PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
  end

  // TX FSM
  st_t tx_st, tx_nx;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0] tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic tx_par, tx_tick, tx_nxt;

  assign tx_tick = (tx_cnt == tx_div);
  assign tx_busy = (tx_st != S_IDLE) || !tx_empty;

  always_ff @(posedge clk) begin
    if (!rstn) tx_st <= S_IDLE;
    else       tx_st <= tx_nx;
  end

  always_comb begin
    tx_nx = tx_st;
    unique case (tx_st)
      S_IDLE:  if (!tx_empty) tx_nx = S_START;
      S_START: if (tx_tick) tx_nx = S_DATA;
      S_DATA:
        if (tx_tick && tx_bit == LAST_D)
          tx_nx = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (tx_tick) tx_nx = S_STOP;
      S_STOP:
        if (tx_tick && tx_bit == LAST_S)
          tx_nx = S_IDLE;
      default: tx_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    tx_nxt = 1'b1;
    unique case (tx_st)
      S_IDLE:  tx_pop = !tx_empty;
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = tx_sh[0];
      S_PAR:   tx_nxt = tx_par;
      default: tx_nxt = 1'b1;
    endcase
  end

  // txd is registered, so the line lags the state by one clock
  always_ff @(posedge clk) begin
    if (!rstn) begin
      txd    <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_div <= 16'd3;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      txd <= tx_nxt;
      if (tx_st == S_IDLE || tx_tick) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 16'd1;
      if (tx_nx != tx_st) tx_bit <= '0;
      else if (tx_tick) tx_bit <= tx_bit + 3'd1;
      if (tx_pop) begin
        tx_div <= div_eff;
        tx_sh  <= tx_head;
        tx_par <= ^tx_head ^ ODD;
      end else if (tx_st == S_DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
      end
    end
  end

  // RX input select and synchroniser
  logic rx_in, rx_s1, rx_s2, rx_s3, rx_fall;
`ifdef UART_LOOPBACK_EN
  assign rx_in = lpbk ? txd : rxd;
`else
  logic lpbk_unused;
  assign lpbk_unused = lpbk;
  assign rx_in = rxd;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 && !rx_s2;

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wp, rx_rp;
  logic rx_full, rx_empty, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_sh;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PONE;
      if (rx_pop)  rx_rp <= rx_rp + PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // RX FSM
  st_t rx_st, rx_nx;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0] rx_bit;
  logic rx_pbit, rx_tick, rx_mid;
  logic [2:0] rx_set;

  assign rx_tick = (rx_cnt == rx_div);
  assign rx_mid  = (rx_cnt == (rx_div >> 1));

  always_ff @(posedge clk) begin
    if (!rstn) rx_st <= S_IDLE;
    else       rx_st <= rx_nx;
  end

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      S_IDLE:  if (rx_fall) rx_nx = S_START;
      S_START: if (rx_mid) rx_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:
        if (rx_tick && rx_bit == LAST_D)
          rx_nx = HAS_PAR ? S_PAR : S_STOP;
      S_PAR:   if (rx_tick) rx_nx = S_STOP;
      S_STOP:  if (rx_tick) rx_nx = S_IDLE;
      default: rx_nx = S_IDLE;
    endcase
  end

  // stop-bit verdict, priority frame > parity > overrun
  always_comb begin
    rx_set  = 3'b000;
    rx_push = 1'b0;
    unique case (rx_st)
      S_STOP:
        if (rx_tick) begin
          if (!rx_s2) rx_set[0] = 1'b1;
          else if (HAS_PAR && rx_pbit != (^rx_sh ^ ODD))
            rx_set[1] = 1'b1;
          else if (rx_full) rx_set[2] = 1'b1;
          else rx_push = 1'b1;
        end
      default: rx_push = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_div  <= 16'd3;
      rx_sh   <= '0;
      rx_pbit <= 1'b0;
      err     <= 3'b000;
    end else begin
      err <= (err & ~{3{err_clr}}) | rx_set;
      if (rx_st == S_IDLE && rx_fall) rx_div <= div_eff;
      if (rx_st == S_IDLE || rx_nx != rx_st || rx_tick)
        rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      if (rx_nx != rx_st) rx_bit <= '0;
      else if (rx_tick) rx_bit <= rx_bit + 3'd1;
      if (rx_st == S_DATA && rx_tick)
        rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
      if (rx_st == S_PAR && rx_tick) rx_pbit <= rx_s2;
    end
  end

endmodule
